// File: rtl/jtag_tap.sv
// JTAG TAP responder oversampled in the clk_i domain: synchronises the TAP pins,
// runs the 1149.1 state machine on TCK rising edges and serves IDCODE, BYPASS and one USER DR.
module jtag_tap #(
    parameter int unsigned           IR_WIDTH   = 5,
    parameter logic [31:0]           IDCODE     = 32'h10000DB3,
    parameter logic [IR_WIDTH-1:0]   USER_INSTR = 'h02,
    parameter int unsigned           DR_WIDTH   = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    input  logic                trst_ni,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic                tlr_o,
    output logic [IR_WIDTH-1:0] ir_o,
    input  logic [DR_WIDTH-1:0] user_capture_i,
    output logic [DR_WIDTH-1:0] user_data_o,
    output logic                user_update_o
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 1;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 1;

    // Pin bits packed as {trst_n, tdi, tms, tck}
    logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic                tck_dly_q, tck_dly_d;
    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;
    logic [DR_WIDTH-1:0] user_sr_q, user_sr_d, user_data_q, user_data_d;
    logic                bypass_q, bypass_d;
    logic                user_update_q, user_update_d;
    logic                tdo_q, tdo_d, tdo_oe_q, tdo_oe_d, tlr_q, tlr_d;

    logic tck_s, tms_s, tdi_s, trst_s, tck_rise, tck_fall, sel_idcode, sel_user;

    assign tck_s    = sync2_q[0];
    assign tms_s    = sync2_q[1];
    assign tdi_s    = sync2_q[2];
    assign trst_s   = sync2_q[3];
    assign tck_rise = tck_s & ~tck_dly_q;
    assign tck_fall = ~tck_s & tck_dly_q;

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = !sel_idcode && (ir_q == USER_INSTR);

    always_comb begin
        sync1_d   = {trst_ni, tdi_i, tms_i, tck_i};
        sync2_d   = sync1_q;
        tck_dly_d = tck_s;
    end

    always_comb begin
        state_d = state_q;
        if (!trst_s) begin
            state_d = TLR;
        end else if (tck_rise) begin
            unique case (state_q)
                TLR:      state_d = tms_s ? TLR      : RTI;
                RTI:      state_d = tms_s ? SEL_DR   : RTI;
                SEL_DR:   state_d = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   state_d = tms_s ? EX1_DR   : SH_DR;
                SH_DR:    state_d = tms_s ? EX1_DR   : SH_DR;
                EX1_DR:   state_d = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_d = tms_s ? EX2_DR   : PAUSE_DR;
                EX2_DR:   state_d = tms_s ? UPD_DR   : SH_DR;
                UPD_DR:   state_d = tms_s ? SEL_DR   : RTI;
                SEL_IR:   state_d = tms_s ? TLR      : CAP_IR;
                CAP_IR:   state_d = tms_s ? EX1_IR   : SH_IR;
                SH_IR:    state_d = tms_s ? EX1_IR   : SH_IR;
                EX1_IR:   state_d = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_d = tms_s ? EX2_IR   : PAUSE_IR;
                EX2_IR:   state_d = tms_s ? UPD_IR   : SH_IR;
                UPD_IR:   state_d = tms_s ? SEL_DR   : RTI;
                default:  state_d = TLR;
            endcase
        end
    end

    // Register actions are keyed on the state occupied before the TCK edge.
    always_comb begin
        ir_sr_d       = ir_sr_q;
        ir_d          = ir_q;
        idcode_sr_d   = idcode_sr_q;
        user_sr_d     = user_sr_q;
        bypass_d      = bypass_q;
        user_data_d   = user_data_q;
        user_update_d = 1'b0;
        tdo_d         = tdo_q;
        tdo_oe_d      = tdo_oe_q;
        if (!trst_s) begin
            ir_d     = IR_IDCODE;
            tdo_oe_d = 1'b0;
        end else if (tck_rise) begin
            case (state_q)
                CAP_IR: ir_sr_d = IR_CAPTURE;
                SH_IR: begin
                    ir_sr_d               = ir_sr_q >> 1;
                    ir_sr_d[IR_WIDTH-1]   = tdi_s;
                end
                UPD_IR: ir_d = ir_sr_q;
                CAP_DR: begin
                    if (sel_idcode)    idcode_sr_d = IDCODE;
                    else if (sel_user) user_sr_d   = user_capture_i;
                    else               bypass_d    = 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode) begin
                        idcode_sr_d     = idcode_sr_q >> 1;
                        idcode_sr_d[31] = tdi_s;
                    end else if (sel_user) begin
                        user_sr_d             = user_sr_q >> 1;
                        user_sr_d[DR_WIDTH-1] = tdi_s;
                    end else begin
                        bypass_d = tdi_s;
                    end
                end
                UPD_DR: begin
                    if (sel_user) begin
                        user_data_d   = user_sr_q;
                        user_update_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_d == TLR) ir_d = IR_IDCODE;
        end else if (tck_fall) begin
            if (state_q == SH_IR) begin
                tdo_d    = ir_sr_q[0];
                tdo_oe_d = 1'b1;
            end else if (state_q == SH_DR) begin
                tdo_d    = sel_idcode ? idcode_sr_q[0] : (sel_user ? user_sr_q[0] : bypass_q);
                tdo_oe_d = 1'b1;
            end else begin
                tdo_oe_d = 1'b0;
            end
        end
        tlr_d = (state_d == TLR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q       <= 4'b0000;
            sync2_q       <= 4'b0000;
            tck_dly_q     <= 1'b0;
            state_q       <= TLR;
            ir_sr_q       <= IR_CAPTURE;
            ir_q          <= IR_IDCODE;
            idcode_sr_q   <= IDCODE;
            user_sr_q     <= '0;
            bypass_q      <= 1'b0;
            user_data_q   <= '0;
            user_update_q <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
            tlr_q         <= 1'b1;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            tck_dly_q     <= tck_dly_d;
            state_q       <= state_d;
            ir_sr_q       <= ir_sr_d;
            ir_q          <= ir_d;
            idcode_sr_q   <= idcode_sr_d;
            user_sr_q     <= user_sr_d;
            bypass_q      <= bypass_d;
            user_data_q   <= user_data_d;
            user_update_q <= user_update_d;
            tdo_q         <= tdo_d;
            tdo_oe_q      <= tdo_oe_d;
            tlr_q         <= tlr_d;
        end
    end

    assign tdo_o         = tdo_q;
    assign tdo_oe_o      = tdo_oe_q;
    assign tlr_o         = tlr_q;
    assign ir_o          = ir_q;
    assign user_data_o   = user_data_q;
    assign user_update_o = user_update_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: drives TCK/TMS/TDI from the clk_i domain and checks
// IDCODE, BYPASS, USER scans, TRST and TMS-reset behaviour against hand-computed values.
module tb_jtag_tap;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tck_i = 1'b0;
    logic        tms_i = 1'b1;
    logic        tdi_i = 1'b0;
    logic        trst_ni = 1'b1;
    logic        tdo_o, tdo_oe_o, tlr_o, user_update_o;
    logic [4:0]  ir_o;
    logic [31:0] user_capture_i = 32'h0;
    logic [31:0] user_data_o;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;

    localparam int HALF = 5;
    localparam int FAST = 3;

    jtag_tap dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tck_i          (tck_i),
        .tms_i          (tms_i),
        .tdi_i          (tdi_i),
        .trst_ni        (trst_ni),
        .tdo_o          (tdo_o),
        .tdo_oe_o       (tdo_oe_o),
        .tlr_o          (tlr_o),
        .ir_o           (ir_o),
        .user_capture_i (user_capture_i),
        .user_data_o    (user_data_o),
        .user_update_o  (user_update_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (user_update_o === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One TCK period; tdo/oe are sampled just before the rise, i.e. the result of the previous fall.
    task automatic jtag_clk(input logic tms, input logic tdi, input int half,
                            output logic tdo_s, output logic oe_s);
        tms_i = tms;
        tdi_i = tdi;
        wait_clk(half);
        tdo_s = tdo_o;
        oe_s  = tdo_oe_o;
        tck_i = 1'b1;
        wait_clk(half);
        tck_i = 1'b0;
    endtask

    task automatic tms_seq(input logic [7:0] seq, input int n, input int half);
        logic t, o;
        for (int i = 0; i < n; i++) jtag_clk(seq[i], 1'b0, half, t, o);
    endtask

    // Starts in a Shift state; last bit leaves with TMS=1.
    task automatic shift_bits(input int n, input logic [63:0] din, input int half,
                              output logic [63:0] dout, output logic oe_all);
        logic t, o;
        dout   = '0;
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            jtag_clk(i == n - 1, din[i], half, t, o);
            dout[i] = t;
            oe_all  = oe_all & o;
        end
    endtask

    // RTI -> Shift-DR: 1,0,0 ; RTI -> Shift-IR: 1,1,0,0 ; Exit1 -> Update -> RTI: 1,0
    task automatic goto_shift_dr(input int half); tms_seq(8'b001, 3, half); endtask
    task automatic goto_shift_ir(input int half); tms_seq(8'b0011, 4, half); endtask
    task automatic finish_scan(input int half);   tms_seq(8'b01, 2, half); endtask

    task automatic test_reset;
        wait_clk(3);
        rst_ni = 1'b1;
        wait_clk(3);
        checks++; if (tlr_o !== 1'b1) begin errors++; $display("FAIL reset_tlr got %b exp 1", tlr_o); end
        checks++; if (ir_o !== 5'h01) begin errors++; $display("FAIL reset_ir got %h exp 01", ir_o); end
        checks++; if (tdo_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", tdo_oe_o); end
        checks++; if (tdo_o !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", tdo_o); end
        checks++; if (user_data_o !== 32'h0) begin errors++; $display("FAIL reset_user_data got %h exp 0", user_data_o); end
        checks++; if (user_update_o !== 1'b0) begin errors++; $display("FAIL reset_user_update got %b exp 0", user_update_o); end
    endtask

    task automatic test_idcode;
        logic [63:0] d;
        logic oe;
        tms_seq(8'b0010, 4, HALF);
        checks++; if (tlr_o !== 1'b0) begin errors++; $display("FAIL idcode_tlr_low got %b exp 0", tlr_o); end
        shift_bits(32, 64'h0, HALF, d, oe);
        checks++; if (d[31:0] !== 32'h10000DB3) begin errors++; $display("FAIL idcode_scan got %h exp 10000db3", d[31:0]); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL idcode_oe got %b exp 1", oe); end
        finish_scan(HALF);
        wait_clk(4);
        checks++; if (tdo_oe_o !== 1'b0) begin errors++; $display("FAIL idcode_oe_after got %b exp 0", tdo_oe_o); end
    endtask

    task automatic test_bypass;
        logic [63:0] d;
        logic oe;
        goto_shift_ir(HALF);
        shift_bits(5, 64'h1F, HALF, d, oe);
        checks++; if (d[4:0] !== 5'b00001) begin errors++; $display("FAIL ir_capture got %b exp 00001", d[4:0]); end
        finish_scan(HALF);
        wait_clk(4);
        checks++; if (ir_o !== 5'h1F) begin errors++; $display("FAIL ir_update got %h exp 1f", ir_o); end
        goto_shift_dr(HALF);
        shift_bits(9, {55'h0, 1'b0, 8'hA5}, HALF, d, oe);
        checks++; if (d[8:0] !== 9'h14A) begin errors++; $display("FAIL bypass_scan got %h exp 14a", d[8:0]); end
        finish_scan(HALF);
    endtask

    task automatic test_user;
        logic [63:0] d;
        logic oe;
        int c0;
        goto_shift_ir(HALF);
        shift_bits(5, 64'h02, HALF, d, oe);
        finish_scan(HALF);
        wait_clk(4);
        checks++; if (ir_o !== 5'h02) begin errors++; $display("FAIL user_ir got %h exp 02", ir_o); end
        user_capture_i = 32'hCAFE0001;
        c0 = upd_cnt;
        goto_shift_dr(HALF);
        shift_bits(32, {32'h0, 32'h12345678}, HALF, d, oe);
        checks++; if (d[31:0] !== 32'hCAFE0001) begin errors++; $display("FAIL user_capture got %h exp cafe0001", d[31:0]); end
        checks++; if (upd_cnt != c0) begin errors++; $display("FAIL user_early_update got %0d exp 0", upd_cnt - c0); end
        finish_scan(HALF);
        wait_clk(4);
        checks++; if (user_data_o !== 32'h12345678) begin errors++; $display("FAIL user_data got %h exp 12345678", user_data_o); end
        checks++; if (upd_cnt - c0 != 1) begin errors++; $display("FAIL user_update_pulse got %0d exp 1", upd_cnt - c0); end
    endtask

    task automatic test_trst;
        logic t, o;
        goto_shift_dr(HALF);
        for (int i = 0; i < 3; i++) jtag_clk(1'b0, 1'b1, HALF, t, o);
        wait_clk(4);
        checks++; if (tdo_oe_o !== 1'b1) begin errors++; $display("FAIL trst_pre_oe got %b exp 1", tdo_oe_o); end
        trst_ni = 1'b0;
        wait_clk(2);
        trst_ni = 1'b1;
        wait_clk(1);
        checks++; if (tlr_o !== 1'b1) begin errors++; $display("FAIL trst_tlr got %b exp 1", tlr_o); end
        checks++; if (ir_o !== 5'h01) begin errors++; $display("FAIL trst_ir got %h exp 01", ir_o); end
        checks++; if (tdo_oe_o !== 1'b0) begin errors++; $display("FAIL trst_oe got %b exp 0", tdo_oe_o); end
        checks++; if (user_data_o !== 32'h12345678) begin errors++; $display("FAIL trst_user_data got %h exp 12345678", user_data_o); end
        wait_clk(4);
    endtask

    task automatic test_tms_reset;
        tms_seq(8'b0, 1, HALF);
        tms_seq(8'b010011, 6, HALF);
        tms_seq(8'hFF, 4, HALF);
        wait_clk(2);
        checks++; if (tlr_o !== 1'b0) begin errors++; $display("FAIL tms_reset_4 got %b exp 0", tlr_o); end
        tms_seq(8'hFF, 1, HALF);
        wait_clk(2);
        checks++; if (tlr_o !== 1'b1) begin errors++; $display("FAIL tms_reset_5 got %b exp 1", tlr_o); end
        checks++; if (ir_o !== 5'h01) begin errors++; $display("FAIL tms_reset_ir got %h exp 01", ir_o); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] d;
        logic oe;
        int c0;
        tms_seq(8'b0, 1, FAST);
        goto_shift_ir(FAST);
        shift_bits(5, 64'h02, FAST, d, oe);
        finish_scan(FAST);
        user_capture_i = 32'h0F1E2D3C;
        c0 = upd_cnt;
        goto_shift_dr(FAST);
        shift_bits(64, 64'hDEADBEEF_13579BDF, FAST, d, oe);
        checks++; if (d !== 64'h13579BDF_0F1E2D3C) begin errors++; $display("FAIL fast_scan got %h exp 13579bdf0f1e2d3c", d); end
        finish_scan(FAST);
        wait_clk(4);
        checks++; if (user_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL fast_user_data got %h exp deadbeef", user_data_o); end
        checks++; if (upd_cnt - c0 != 1) begin errors++; $display("FAIL fast_update_pulse got %0d exp 1", upd_cnt - c0); end
    endtask

    initial begin
        test_reset;
        test_idcode;
        test_bypass;
        test_user;
        test_trst;
        test_tms_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
